// File: rtl/xor_accum_decoder_if.sv
// Snapshot-in / decoded-word-out handshake bundle for the XOR-accumulate decoder.
// slave is the decoder's view; master is the capture/comparator side.
interface xor_accum_decoder_if #(
  parameter int W = 19
);
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         in_ready;
  logic         sync_valid;
  logic [W-1:0] sync_data;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic         out_parity;
  logic         out_ready;

  modport master (
    output in_valid, in_data, sync_valid, sync_data, out_ready,
    input  in_ready, out_valid, out_data, out_parity
  );

  modport slave (
    input  in_valid, in_data, sync_valid, sync_data, out_ready,
    output in_ready, out_valid, out_data, out_parity
  );
endinterface

// File: rtl/xor_accum_decoder.sv
// Recovers encoder input words as snapshot ^ previous snapshot into a small FIFO.
// One-cycle latency to FIFO head; in_ready drops when full or during resync.
module xor_accum_decoder_fifo #(
  parameter int W     = 19,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [W-1:0]             head,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;

  // Storage is not reset; consumers gate the head with a non-zero count.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= push_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rptr];
endmodule

module xor_accum_decoder #(
  parameter int W     = 19,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  xor_accum_decoder_if.slave   bus,
  output logic [CNT_W-1:0]     word_cnt,
  output logic                 bit0
);
  localparam int          AW       = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [W-1:0] prev;
  logic [W-1:0] head;
  logic [AW:0]  count;
  logic         accept;
  logic         pop;
  logic         have_word;
  logic [W-1:0] shown;

  // Gating with reset keeps in_ready low while the block is held in reset.
  assign bus.in_ready = reset && (count < FULL_CNT) && !bus.sync_valid;
  assign accept       = bus.in_valid && bus.in_ready;
  assign have_word    = (count != '0);
  assign pop          = have_word && bus.out_ready;

  xor_accum_decoder_fifo #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (accept),
    .push_data (bus.in_data ^ prev),
    .pop       (pop),
    .head      (head),
    .count     (count)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev     <= '0;
      word_cnt <= '0;
    end else if (bus.sync_valid) begin
      prev <= bus.sync_data;
    end else if (accept) begin
      prev     <= bus.in_data;
      word_cnt <= word_cnt + 1'b1;
    end
  end

  assign shown          = have_word ? head : '0;
  assign bus.out_valid  = have_word;
  assign bus.out_data   = shown;
  assign bus.out_parity = ^shown;
  assign bit0           = prev[0];
endmodule

// File: tb/tb_xor_accum_decoder.sv
// Directed bench for xor_accum_decoder: vector table plus full/reset/wrap sequences.
module tb_xor_accum_decoder;
  localparam int W     = 19;
  localparam int DEPTH = 4;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic [CNT_W-1:0] word_cnt;
  logic             bit0;
  int               n_vec = 0;
  int               n_err = 0;

  xor_accum_decoder_if #(.W(W)) bus ();

  xor_accum_decoder #(.W(W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .word_cnt (word_cnt),
    .bit0     (bit0)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         iv;
    logic [W-1:0] d;
    logic         sv;
    logic [W-1:0] sd;
    logic         ordy;
    logic         e_ir;
    logic         e_ov;
    logic [W-1:0] e_od;
    logic         e_par;
    logic [15:0]  e_cnt;
    logic         e_b0;
  } vec_t;

  vec_t vt [11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    #2;
    reset = 1'b1;
  endtask

  task automatic drive(input logic iv, input logic [W-1:0] d, input logic ordy);
    bus.in_valid  = iv;
    bus.in_data   = d;
    bus.out_ready = ordy;
  endtask

  initial begin
    logic [W-1:0] snaps [5];
    logic [W-1:0] drain [4];

    reset          = 1'b0;
    bus.in_valid   = 1'b0;
    bus.in_data    = '0;
    bus.sync_valid = 1'b0;
    bus.sync_data  = '0;
    bus.out_ready  = 1'b0;

    //            iv  d           sv  sd          ordy ir  ov  od          par  cnt b0
    vt[0]  = '{1'b1, 19'h00001, 1'b0, 19'h00000, 1'b1, 1'b1, 1'b1, 19'h00001, 1'b1, 16'd1, 1'b1};
    vt[1]  = '{1'b1, 19'h00003, 1'b0, 19'h00000, 1'b1, 1'b1, 1'b1, 19'h00002, 1'b1, 16'd2, 1'b1};
    vt[2]  = '{1'b1, 19'h7FFFF, 1'b0, 19'h00000, 1'b1, 1'b1, 1'b1, 19'h7FFFC, 1'b1, 16'd3, 1'b1};
    vt[3]  = '{1'b0, 19'h00000, 1'b0, 19'h00000, 1'b1, 1'b1, 1'b0, 19'h00000, 1'b0, 16'd3, 1'b1};
    vt[4]  = '{1'b1, 19'h12344, 1'b1, 19'h12345, 1'b1, 1'b0, 1'b0, 19'h00000, 1'b0, 16'd3, 1'b1};
    vt[5]  = '{1'b1, 19'h12344, 1'b0, 19'h00000, 1'b0, 1'b1, 1'b1, 19'h00001, 1'b1, 16'd4, 1'b0};
    vt[6]  = '{1'b0, 19'h00000, 1'b0, 19'h00000, 1'b1, 1'b1, 1'b0, 19'h00000, 1'b0, 16'd4, 1'b0};
    vt[7]  = '{1'b1, 19'h00010, 1'b0, 19'h00000, 1'b0, 1'b1, 1'b1, 19'h12354, 1'b1, 16'd5, 1'b0};
    vt[8]  = '{1'b0, 19'h00000, 1'b1, 19'h00007, 1'b1, 1'b0, 1'b0, 19'h00000, 1'b0, 16'd5, 1'b1};
    vt[9]  = '{1'b1, 19'h00006, 1'b0, 19'h00000, 1'b0, 1'b1, 1'b1, 19'h00001, 1'b1, 16'd6, 1'b0};
    vt[10] = '{1'b0, 19'h00000, 1'b0, 19'h00000, 1'b1, 1'b1, 1'b0, 19'h00000, 1'b0, 16'd6, 1'b0};

    #12;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data", 32'(bus.out_data), 32'd0);
    chk("rst_out_parity", 32'(bus.out_parity), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_word_cnt", 32'(word_cnt), 32'd0);
    chk("rst_bit0", 32'(bit0), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      drive(vt[i].iv, vt[i].d, vt[i].ordy);
      bus.sync_valid = vt[i].sv;
      bus.sync_data  = vt[i].sd;
      #1;
      chk($sformatf("v%0d_in_ready", i), 32'(bus.in_ready), 32'(vt[i].e_ir));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_out_valid", i), 32'(bus.out_valid), 32'(vt[i].e_ov));
      if (vt[i].e_ov) begin
        chk($sformatf("v%0d_out_data", i), 32'(bus.out_data), 32'(vt[i].e_od));
        chk($sformatf("v%0d_out_parity", i), 32'(bus.out_parity), 32'(vt[i].e_par));
      end
      chk($sformatf("v%0d_word_cnt", i), 32'(word_cnt), 32'(vt[i].e_cnt));
      chk($sformatf("v%0d_bit0", i), 32'(bit0), 32'(vt[i].e_b0));
    end
    @(negedge clk);
    bus.sync_valid = 1'b0;
    drive(1'b0, '0, 1'b0);

    // Fill to full, hold the fifth snapshot, pop once while full, then drain.
    do_reset();
    snaps = '{19'h00001, 19'h00002, 19'h00004, 19'h00008, 19'h00010};
    drain = '{19'h00003, 19'h00006, 19'h0000C, 19'h00018};
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      drive(1'b1, snaps[k], 1'b0);
      #1;
      chk($sformatf("fill%0d_in_ready", k), 32'(bus.in_ready), 32'd1);
    end
    @(negedge clk);
    drive(1'b1, snaps[4], 1'b0);
    #1;
    chk("full_in_ready", 32'(bus.in_ready), 32'd0);
    chk("full_word_cnt", 32'(word_cnt), 32'd4);
    chk("full_head", 32'(bus.out_data), 32'h1);
    @(negedge clk);
    chk("held_word_cnt", 32'(word_cnt), 32'd4);
    bus.out_ready = 1'b1;
    #1;
    chk("full_pop_in_ready", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    chk("after_pop_word_cnt", 32'(word_cnt), 32'd4);
    chk("after_pop_head", 32'(bus.out_data), 32'h3);
    bus.out_ready = 1'b0;
    #1;
    chk("after_pop_in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    chk("deferred_word_cnt", 32'(word_cnt), 32'd5);
    bus.in_valid = 1'b0;
    #1;
    chk("refull_in_ready", 32'(bus.in_ready), 32'd0);
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      bus.out_ready = 1'b1;
      #1;
      chk($sformatf("drain%0d_valid", j), 32'(bus.out_valid), 32'd1);
      chk($sformatf("drain%0d_data", j), 32'(bus.out_data), 32'(drain[j]));
    end
    @(negedge clk);
    chk("drained_valid", 32'(bus.out_valid), 32'd0);

    // Asynchronous reset with two words buffered.
    do_reset();
    @(negedge clk);
    drive(1'b1, 19'h00003, 1'b0);
    @(negedge clk);
    drive(1'b1, 19'h00007, 1'b0);
    @(negedge clk);
    drive(1'b0, '0, 1'b0);
    chk("pre_rst_valid", 32'(bus.out_valid), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_data", 32'(bus.out_data), 32'd0);
    chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("mid_rst_word_cnt", 32'(word_cnt), 32'd0);
    chk("mid_rst_bit0", 32'(bit0), 32'd0);
    #1;
    reset = 1'b1;
    @(negedge clk);
    drive(1'b1, 19'h00005, 1'b1);
    @(posedge clk);
    #1;
    chk("post_rst_valid", 32'(bus.out_valid), 32'd1);
    chk("post_rst_data", 32'(bus.out_data), 32'h5);
    chk("post_rst_word_cnt", 32'(word_cnt), 32'd1);
    @(negedge clk);
    drive(1'b0, '0, 1'b1);

    // word_cnt wrap after 65537 pushes.
    do_reset();
    for (int i = 0; i < 65537; i++) begin
      @(negedge clk);
      drive(1'b1, 19'(i), 1'b1);
    end
    @(negedge clk);
    drive(1'b0, '0, 1'b1);
    #1;
    chk("wrap_word_cnt", 32'(word_cnt), 32'd1);
    chk("wrap_bit0", 32'(bit0), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
